// File: rtl/alu_sequencer.sv
// Register-file front end for the 8-bit ALU: operand and mode regs out, result write-back, response on valid/ready.
// Latency: load 1 cycle, ALU op 3 cycles to rsp_valid; rsp_ready low holds RESP with outputs frozen.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_srca,
    input  logic [AW-1:0]    cmd_srcb,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_mode,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  rf [NREG];
    logic [AW-1:0]     dst_q;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = cmd_load ? RESP : EXEC;
                end
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is taken while reset is still asserted.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    cmd_ready = ~rst;
            RESP:    rsp_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    // Operands are registered at accept, so a write-back to srca/srcb cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            dst_q    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dst_q <= cmd_dst;
                        if (cmd_load) begin
                            rf[cmd_dst] <= cmd_imm;
                            rsp_data    <= cmd_imm;
                            rsp_zero    <= (cmd_imm == '0);
                        end else begin
                            alu_a    <= rf[cmd_srca];
                            alu_b    <= rf[cmd_srcb];
                            alu_mode <= cmd_op;
                        end
                    end
                end
                EXEC: begin
                    rf[dst_q] <= alu_out;
                    rsp_data  <= alu_out;
                    rsp_zero  <= (alu_out == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU on the operand side.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic [1:0] cmd_dst;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_mode;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;

    int total = 0;
    int bad   = 0;

    logic [7:0] obs_a;
    logic [7:0] obs_b;
    logic [2:0] obs_mode;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, INC = 3'b010, DEC = 3'b011;
    localparam logic [2:0] AND = 3'b100, OR  = 3'b101, XOR = 3'b110, NOT = 3'b111;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_mode)
            ADD:     alu_out = alu_a + alu_b;
            SUB:     alu_out = alu_a - alu_b;
            INC:     alu_out = alu_a + 8'd1;
            DEC:     alu_out = alu_a - 8'd1;
            AND:     alu_out = alu_a & alu_b;
            OR:      alu_out = alu_a | alu_b;
            XOR:     alu_out = alu_a ^ alu_b;
            default: alu_out = ~alu_a;
        endcase
    end

    alu_sequencer #(.WIDTH(8), .NREG(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command; hold = cycles of rsp_ready low in RESP before the handshake.
    task automatic run(input string tag, input logic ld, input logic [2:0] op,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d,
                       input logic [7:0] imm, input logic [7:0] exp_data,
                       input logic exp_zero, input int exp_lat, input int hold);
        int n;
        int lat;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_dst   = d;
        cmd_imm   = imm;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, n < 50, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        obs_a    = alu_a;
        obs_b    = alu_b;
        obs_mode = alu_mode;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_zero"}, rsp_zero, exp_zero);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"}, rsp_valid, 1);
            chk({tag, "_bp_data"}, rsp_data, exp_data);
            chk({tag, "_bp_ready"}, cmd_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, rsp_valid, 0);
        chk({tag, "_idle_ready"}, cmd_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'b0;
        cmd_srca  = 2'd0;
        cmd_srcb  = 2'd0;
        cmd_dst   = 2'd0;
        cmd_imm   = 8'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        run("ld_r0", 1, ADD, 0, 0, 0, 8'h05, 8'h05, 0, 1, 0);
        run("ld_r1", 1, ADD, 0, 0, 1, 8'h03, 8'h03, 0, 1, 0);
        run("add_r0r1", 0, ADD, 0, 1, 2, 8'h00, 8'h08, 0, 3, 0);
        chk("add_alu_a", obs_a, 8'h05);
        chk("add_alu_b", obs_b, 8'h03);
        chk("add_alu_mode", obs_mode, ADD);
        run("add_r2r2", 0, ADD, 2, 2, 2, 8'h00, 8'h10, 0, 3, 0);
        run("ld_r3ff", 1, ADD, 0, 0, 3, 8'hFF, 8'hFF, 0, 1, 0);
        run("inc_wrap", 0, INC, 3, 0, 3, 8'h00, 8'h00, 1, 3, 0);
        run("dec_wrap", 0, DEC, 3, 0, 3, 8'h00, 8'hFF, 0, 3, 0);
        run("sub_neg", 0, SUB, 1, 0, 3, 8'h00, 8'hFE, 0, 3, 0);
        run("not_r0", 0, NOT, 0, 1, 2, 8'h00, 8'hFA, 0, 3, 0);
        run("and_r0r1", 0, AND, 0, 1, 2, 8'h00, 8'h01, 0, 3, 0);
        run("ld_zero", 1, ADD, 0, 0, 3, 8'h00, 8'h00, 1, 1, 0);
        run("xor_bp", 0, XOR, 0, 1, 2, 8'h00, 8'h06, 0, 3, 10);

        // Reset while the add into R2 sits in EXEC.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = ADD;
        cmd_srca  = 2'd0;
        cmd_srcb  = 2'd1;
        cmd_dst   = 2'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mid_alu_a_pre", alu_a, 8'h05);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b", alu_b, 0);
        chk("mid_rsp_data", rsp_data, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_cmd_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", cmd_ready, 1);
        run("rst_r2r2", 0, ADD, 2, 2, 2, 8'h00, 8'h00, 1, 3, 0);
        run("rst_r0r1", 0, ADD, 0, 1, 3, 8'h00, 8'h00, 1, 3, 0);

        run("ld_r0_5a", 1, ADD, 0, 0, 0, 8'h5A, 8'h5A, 0, 1, 0);
        run("xor_hazard", 0, XOR, 0, 0, 0, 8'h00, 8'h00, 1, 3, 0);
        run("ld_r1_03", 1, ADD, 0, 0, 1, 8'h03, 8'h03, 0, 1, 0);
        run("or_r0r1", 0, OR, 0, 1, 2, 8'h00, 8'h03, 0, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller that sits on the operand side of the 8-bit ALU.
- Holds a 4-entry x 8-bit register file, accepts operation commands on a valid/ready interface, and drives the ALU's A, B and mode inputs from registered values.
- Captures the ALU result, writes it back to the register file, and returns it on a valid/ready response interface.
- Lets upstream logic run multi-step arithmetic without wiring the ALU combinationally.

Parameters:
- WIDTH, 8, datapath width; must match the ALU (8).
- NREG, 4, number of register-file entries.
- AW, 2, register address width; equals log2(NREG).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_load  in  1  1 = load cmd_imm into cmd_dst; 0 = ALU operation.
- cmd_op  in  3  ALU mode code: 000 add, 001 sub, 010 inc, 011 dec, 100 and, 101 or, 110 xor, 111 not.
- cmd_srca  in  AW  register index for operand A.
- cmd_srcb  in  AW  register index for operand B.
- cmd_dst  in  AW  destination register index.
- cmd_imm  in  WIDTH  immediate value for loads.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_mode  out  3  mode to the ALU.
- alu_out  in  WIDTH  ALU result (combinational from alu_a, alu_b, alu_mode).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  result, or loaded value for a load command.
- rsp_zero  out  1  rsp_data == 0.

Behaviour:
- Reset (async, rst=1): all state cleared immediately.
  - FSM goes to IDLE; register file is all 0.
  - alu_a, alu_b, alu_mode, rsp_data = 0; rsp_valid = 0; rsp_zero = 0.
  - cmd_ready = 0 while rst is high; cmd_ready = 1 on the first clk after rst deasserts.
- FSM states: IDLE, EXEC, WB, RESP.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid && cmd_ready at edge T, the command fields are latched.
  - Load: the register file entry at cmd_dst is written with cmd_imm at edge T; rsp_data = cmd_imm; go to RESP (rsp_valid high from T+1).
  - ALU operation: alu_a <= reg[srca], alu_b <= reg[srcb], alu_mode <= cmd_op, all at edge T; go to EXEC.
- EXEC:
  - The ALU settles combinationally during this cycle.
  - At edge T+1: reg[dst] <= alu_out, rsp_data <= alu_out, rsp_zero <= (alu_out == 0); go to WB.
- WB:
  - One bubble cycle; alu_* outputs hold their values. Go to RESP at edge T+2.
  - rsp_valid rises at T+3; ALU-op latency from command accept to rsp_valid is 3 cycles.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_zero stay stable until the handshake.
  - On rsp_valid && rsp_ready, return to IDLE; rsp_valid drops the next cycle.
  - cmd_ready = 0 in every state except IDLE, so a new command is never accepted in the same cycle as a response handshake.
- Operand rules:
  - For inc, dec and not, alu_b is still driven from reg[srcb]; the ALU ignores it.
  - srca == srcb is legal.
  - dst may equal srca or srcb. The operands were already registered in IDLE, so write-back uses the old values with no hazard.
- Width: results are modulo 2^WIDTH. No carry or borrow is exported.
  - 0xFF inc -> 0x00 with rsp_zero = 1; 0x00 dec -> 0xFF.
- Back-pressure: rsp_ready held low keeps the FSM in RESP indefinitely; outputs are stable.
- Reset mid-operation, in any state: the in-flight command is discarded, no partial write-back occurs, and the register file is cleared.
- Unused commands: cmd_valid while cmd_ready = 0 is ignored. Upstream must hold the command until it is accepted.
- rsp_zero is also valid for loads (cmd_imm == 0 -> rsp_zero = 1).

Test Plan:
- Loads: load R0 = 0x05, R1 = 0x03 -> each response returns rsp_data 0x05 / 0x03, rsp_zero = 0, and rsp_valid rises 1 cycle after accept.
- Add: op 000, srca R0, srcb R1, dst R2 -> alu_a = 0x05, alu_b = 0x03, alu_mode = 000 one cycle after accept; rsp_data = 0x08 at accept+3; a subsequent add R2+R2 -> 0x10 confirms write-back.
- Wrap and zero: load R3 = 0xFF, inc R3 -> R3 gives 0x00 with rsp_zero = 1. Sub R1 - R0 (0x03 - 0x05) -> 0xFE. Not R0 -> 0xFA.
- Back-pressure: hold rsp_ready = 0 for 10 cycles after an xor of 0x05 ^ 0x03 -> rsp_valid stays 1, rsp_data stays 0x06, cmd_ready stays 0; release -> IDLE the next cycle.
- Reset mid-op: assert rst during EXEC of an add into R2 -> outputs go to 0 immediately; after release, add R2+R2 gives 0x00 because the register file was cleared.
- Hazard: xor R0 ^ R0 with dst R0, where R0 = 0x5A -> 0x00 with rsp_zero = 1; a following or R0 | R1 with R1 = 0x03 -> 0x03.
